// File: rtl/fabosc_pkg.sv
// ----------------------------------------------------------------------------
// fabosc_pkg
//   Shared types and helpers for the RCOSC fabric tick generator.
//   - fabosc_state_t : settle / run state of the tick generator
//   - clog2_min1()   : ceil(log2(n)) clamped to at least 1, so that select
//                      fields never collapse to zero width
//   - RCOSC_FREQ_HZ  : nominal fabric oscillator frequency
// ----------------------------------------------------------------------------
package fabosc_pkg;

    localparam int RCOSC_FREQ_HZ = 50_000_000;

    typedef enum logic [0:0] {
        ST_SETTLE,
        ST_RUN
    } fabosc_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fabosc_tick_ch.sv
// ----------------------------------------------------------------------------
// fabosc_tick_ch
//   One tick channel: divider register, down-counter and registered tick.
//   The counter reloads from div_reg whenever the channel is idle (not running,
//   disabled or being realigned) and after every tick, so a new divider only
//   takes effect at the next reload and a running period is never cut short.
// Ports
//   clk    in  fabric clock
//   resetn in  synchronous active-low reset
//   run    in  generator has finished settling
//   en     in  channel enable (level)
//   we     in  divider write strobe for this channel
//   wdata  in  divider value to write
//   sync   in  realign request (forces reload, suppresses tick)
//   tick   out one-cycle tick strobe, registered
// ----------------------------------------------------------------------------
module fabosc_tick_ch #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 49
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run,
    input  logic             en,
    input  logic             we,
    input  logic [DIV_W-1:0] wdata,
    input  logic             sync,
    output logic             tick
);

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic             tick_reg;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_reg  <= DIV_W'(DEFAULT_DIV);
            cnt_reg  <= DIV_W'(DEFAULT_DIV);
            tick_reg <= 1'b0;
        end else begin
            // Reloads below read the pre-edge div_reg, so a write landing on
            // a reload edge only affects the following period.
            if (we) begin
                div_reg <= wdata;
            end

            if (!run || !en || sync) begin
                cnt_reg  <= div_reg;
                tick_reg <= 1'b0;
            end else if (cnt_reg == '0) begin
                cnt_reg  <= div_reg;
                tick_reg <= 1'b1;
            end else begin
                cnt_reg  <= cnt_reg - DIV_W'(1);
                tick_reg <= 1'b0;
            end
        end
    end

    assign tick = tick_reg;

endmodule

// File: rtl/fabosc_tick_gen.sv
// ----------------------------------------------------------------------------
// fabosc_tick_gen
//   Multi-channel programmable tick generator on the 50 MHz RCOSC fabric clock.
//   After reset all outputs stay quiet for SETTLE_CYCLES cycles while the
//   oscillator settles; then each enabled channel emits a one-cycle tick every
//   (divider + 1) cycles.
// Optional feature
//   FABOSC_SYNC_EN : when defined adds input sync; a high sync while running
//                    reloads every channel counter so all channels restart in
//                    phase. Without it the sync port does not exist.
// Ports
//   clk     in  RCOSC fabric clock (post-CLKINT)
//   resetn  in  synchronous active-low reset
//   cfg_we  in  divider write strobe
//   cfg_ch  in  channel select for the write (out-of-range selects ignored)
//   cfg_div in  divider value to write
//   ch_en   in  per-channel enable, level
//   ready   out settling complete
//   tick    out per-channel one-cycle tick strobes, registered
//   sync    in  realign all channels (FABOSC_SYNC_EN only)
// ----------------------------------------------------------------------------
module fabosc_tick_gen
    import fabosc_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int DIV_W         = 16,
    parameter int DEFAULT_DIV   = 49,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            cfg_we,
    input  logic [clog2_min1(NUM_CH)-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]                cfg_div,
    input  logic [NUM_CH-1:0]               ch_en,
    output logic                            ready,
    output logic [NUM_CH-1:0]               tick
`ifdef FABOSC_SYNC_EN
    ,
    input  logic                            sync
`endif
);

    localparam int CH_W = clog2_min1(NUM_CH);
    localparam int SC_W = clog2_min1(SETTLE_CYCLES);
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);

    fabosc_state_t   state_reg;
    logic [SC_W-1:0] settle_cnt_reg;
    logic            ready_reg;
    logic            run;
    logic            sync_int;
    logic [NUM_CH-1:0] ch_we;

`ifdef FABOSC_SYNC_EN
    assign sync_int = sync;
`else
    assign sync_int = 1'b0;
`endif

    // Settling FSM: count out the window, then sit in RUN until reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= ST_SETTLE;
            settle_cnt_reg <= '0;
            ready_reg      <= 1'b0;
        end else if (state_reg == ST_SETTLE) begin
            if (settle_cnt_reg == SETTLE_LAST) begin
                state_reg <= ST_RUN;
                ready_reg <= 1'b1;
            end else begin
                settle_cnt_reg <= settle_cnt_reg + SC_W'(1);
            end
        end else begin
            ready_reg <= 1'b1;
        end
    end

    assign run   = (state_reg == ST_RUN);
    assign ready = ready_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Only in-range selects can match, so writes to cfg_ch >= NUM_CH
            // fall through without touching any channel.
            assign ch_we[gi] = cfg_we && (cfg_ch == CH_W'(gi));

            fabosc_tick_ch #(
                .DIV_W       (DIV_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .clk    (clk),
                .resetn (resetn),
                .run    (run),
                .en     (ch_en[gi]),
                .we     (ch_we[gi]),
                .wdata  (cfg_div),
                .sync   (sync_int),
                .tick   (tick[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_fabosc_tick_gen.sv
module tb_fabosc_tick_gen;

    localparam int NUM_CH      = 3;   // leaves cfg_ch=3 as an out-of-range select
    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = 49;
    localparam int SETTLE      = 1024;

    logic              clk = 1'b0;
    logic              resetn;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] ch_en;
    logic              sync_in;
    logic              ready;
    logic [NUM_CH-1:0] tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fabosc_tick_gen #(
        .NUM_CH        (NUM_CH),
        .DIV_W         (DIV_W),
        .DEFAULT_DIV   (DEFAULT_DIV),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .ch_en   (ch_en),
        .ready   (ready),
        .tick    (tick)
`ifdef FABOSC_SYNC_EN
        ,
        .sync    (sync_in)
`endif
    );

    // Reference model: time-based schedule. For every channel we keep the
    // absolute edge number of its next tick; any reload (idle, disabled,
    // realign or a tick) schedules the next tick div+1 edges later using the
    // divider value in force before that edge.
    int          edge_n = 0;
    int          since_rst = 0;
    bit          m_run = 1'b0;
    logic        m_ready = 1'b0;
    logic [NUM_CH-1:0] m_tick = '0;
    int          m_div [NUM_CH];
    int          m_next[NUM_CH];

    task automatic cycle();
        bit reload;
        @(posedge clk);
        edge_n++;
        if (!resetn) begin
            since_rst = 0;
            m_run     = 1'b0;
            m_ready   = 1'b0;
            m_tick    = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i]  = DEFAULT_DIV;
                m_next[i] = 0;
            end
        end else begin
            since_rst++;
            for (int i = 0; i < NUM_CH; i++) begin
                reload = !m_run || !ch_en[i];
`ifdef FABOSC_SYNC_EN
                reload = reload || sync_in;
`endif
                if (reload) begin
                    m_tick[i] = 1'b0;
                    m_next[i] = edge_n + 1 + m_div[i];
                end else if (edge_n == m_next[i]) begin
                    m_tick[i] = 1'b1;
                    m_next[i] = edge_n + 1 + m_div[i];
                end else begin
                    m_tick[i] = 1'b0;
                end
            end
            if (cfg_we && int'(cfg_ch) < NUM_CH) m_div[cfg_ch] = int'(cfg_div);
            if (since_rst >= SETTLE) begin
                m_run   = 1'b1;
                m_ready = 1'b1;
            end
        end
        #1;
    endtask

    // Advance until channel ch ticks; n = edges taken, -1 if limit expired.
    task automatic wait_tick(input int ch, input int limit, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!tick[ch] && n < limit);
        if (!tick[ch]) n = -1;
    endtask

    task automatic write_div(input int ch, input int val);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_div = DIV_W'(val);
        cycle();
        cfg_we  = 1'b0;
    endtask

    task automatic test_reset();
        int first_ready = -1;
        resetn = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
        ch_en = '0; sync_in = 1'b0;
        cycle();
        cycle();
        checks++;
        if (ready !== 1'b0 || tick !== '0) begin
            errors++;
            $display("FAIL reset_state ready=%b tick=%b required ready=0 tick=000", ready, tick);
        end
        resetn = 1'b1;
        for (int k = 1; k <= SETTLE + 20; k++) begin
            // Divider writes are accepted while settling.
            if (k == 100) begin cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd9; end
            else cfg_we = 1'b0;
            cycle();
            if (ready && first_ready < 0) first_ready = k;
            checks++;
            if (tick !== m_tick || ready !== m_ready) begin
                errors++;
                $display("FAIL settle_cycle%0d tick=%b ready=%b required tick=%b ready=%b",
                         k, tick, ready, m_tick, m_ready);
            end
        end
        checks++;
        if (first_ready !== SETTLE) begin
            errors++;
            $display("FAIL ready_latency got %0d required %0d", first_ready, SETTLE);
        end
    endtask

    task automatic test_default_period();
        int n;
        ch_en[0] = 1'b1;
        for (int p = 0; p < 3; p++) begin
            wait_tick(0, 200, n);
            checks++;
            if (n !== 50) begin
                errors++;
                $display("FAIL ch0_period%0d got %0d required 50", p, n);
            end
        end
        cycle();
        checks++;
        if (tick[0] !== 1'b0) begin
            errors++;
            $display("FAIL ch0_width tick0=%b required 0", tick[0]);
        end
    endtask

    task automatic test_write_midperiod();
        int n;
        int c;
        ch_en[1] = 1'b1;
        wait_tick(1, 100, n);
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL ch1_first got %0d required 10", n);
        end
        c = 0;
        repeat (3) begin cycle(); c++; end
        write_div(1, 3);
        c++;
        wait_tick(1, 100, n);
        checks++;
        if (n < 0 || c + n !== 10) begin
            errors++;
            $display("FAIL ch1_period_in_progress got %0d required 10", (n < 0) ? -1 : c + n);
        end
        for (int p = 0; p < 2; p++) begin
            wait_tick(1, 100, n);
            checks++;
            if (n !== 4) begin
                errors++;
                $display("FAIL ch1_new_period%0d got %0d required 4", p, n);
            end
        end
    endtask

    task automatic test_disable_and_bad_ch();
        int n;
        write_div(2, 7);
        cycle();
        ch_en[2] = 1'b1;
        wait_tick(2, 100, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL ch2_first got %0d required 8", n);
        end
        repeat (3) cycle();
        ch_en[2] = 1'b0;
        cycle();
        ch_en[2] = 1'b1;
        wait_tick(2, 100, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL ch2_reenable got %0d required 8", n);
        end
        write_div(3, 1);
        for (int k = 0; k < 120; k++) begin
            cycle();
            checks++;
            if (tick !== m_tick) begin
                errors++;
                $display("FAIL bad_ch_cycle%0d tick=%b required %b", k, tick, m_tick);
            end
        end
        wait_tick(2, 100, n);
        checks++;
        if (n > 8 || n < 1) begin
            errors++;
            $display("FAIL ch2_after_bad_write got %0d required 1..8", n);
        end
        wait_tick(2, 100, n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL ch2_period_after_bad_write got %0d required 8", n);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        write_div(0, 0);
        wait_tick(0, 100, n);
        for (int k = 0; k < 10; k++) begin
            cycle();
            checks++;
            if (tick[0] !== 1'b1) begin
                errors++;
                $display("FAIL ch0_div0_cycle%0d tick0=%b required 1", k, tick[0]);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 2500; k++) begin
            cfg_we  = ($urandom_range(0, 9) == 0);
            cfg_ch  = 2'($urandom_range(0, 3));
            cfg_div = DIV_W'($urandom_range(0, 20));
            if ($urandom_range(0, 15) == 0) ch_en = NUM_CH'($urandom);
`ifdef FABOSC_SYNC_EN
            sync_in = ($urandom_range(0, 40) == 0);
`endif
            cycle();
            checks++;
            if (tick !== m_tick || ready !== m_ready) begin
                errors++;
                $display("FAIL random_cycle%0d tick=%b ready=%b required tick=%b ready=%b",
                         k, tick, ready, m_tick, m_ready);
            end
        end
        cfg_we = 1'b0;
        sync_in = 1'b0;
    endtask

`ifdef FABOSC_SYNC_EN
    task automatic test_sync();
        int f0 = -1;
        int f1 = -1;
        write_div(0, 4);
        write_div(1, 9);
        ch_en = 3'b011;
        repeat (33) cycle();
        sync_in = 1'b1;
        cycle();
        sync_in = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            if (tick[0] && f0 < 0) f0 = k;
            if (tick[1] && f1 < 0) f1 = k;
            if (k == 20 || k == 30) begin
                checks++;
                if (tick[1:0] !== 2'b11) begin
                    errors++;
                    $display("FAIL sync_coincide_k%0d tick=%b required 11", k, tick[1:0]);
                end
            end
        end
        checks++;
        if (f0 !== 5 || f1 !== 10) begin
            errors++;
            $display("FAIL sync_first got ch0=%0d ch1=%0d required ch0=5 ch1=10", f0, f1);
        end
    endtask
`endif

    task automatic test_reset_midrun();
        ch_en = 3'b111;
        repeat (5) cycle();
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL midrun_ready_drop ready=%b required 0", ready);
        end
        for (int k = 1; k <= SETTLE; k++) begin
            cycle();
            checks++;
            if (tick !== '0 || ready !== (k == SETTLE)) begin
                errors++;
                $display("FAIL resettle_cycle%0d tick=%b ready=%b required tick=000 ready=%b",
                         k, tick, ready, (k == SETTLE));
            end
        end
        for (int k = 0; k < 200; k++) begin
            cycle();
            checks++;
            if (tick !== m_tick || ready !== m_ready) begin
                errors++;
                $display("FAIL after_resettle_cycle%0d tick=%b required %b", k, tick, m_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_write_midperiod();
        test_disable_and_bad_ch();
        test_back_to_back();
        test_random();
`ifdef FABOSC_SYNC_EN
        test_sync();
`endif
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
